cu_mc_hs: RTL and testbench
===========================

Name: cu_mc_hs

Overview:
Second-generation multicycle control unit for the RV32I lab CPU. Moore FSM sequencing fetch, decode, register read, execute, memory and write-back.
- Adds the full branch set, AUIPC, byte/half/word load/store sizing, and ready-based instruction/data memory handshakes with timeout.
- Adds a sticky trap state for illegal encodings and memory timeouts.
- Sits between the IR/ALU flags and the datapath enables.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles for imem_ready/dmem_ready before fault; 0 disables timeout.
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the wait counter (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
zf  in  1  ALU result zero
lt  in  1  ALU signed A<B
ltu  in  1  ALU unsigned A<B
imem_ready  in  1  instruction word valid
dmem_ready  in  1  data access complete
imem_req  out  1  fetch request
pc_step  out  1  PC <= PC+4
pc_jump  out  1  PC load
pc_jump_sel  out  1  0 = PC-relative (imm), 1 = from F register
ir_write  out  1  IR load
regs_write  out  1  register file write
dmem_req  out  1  data access request
dmem_we  out  1  1 = store
dmem_size  out  2  00 byte, 01 half, 10 word
dmem_unsigned  out  1  zero-extend load
alu_op  out  4  ALU operation
alu_lhs_sel  out  1  0 = A reg, 1 = PC
alu_rhs_sel  out  1  0 = B reg, 1 = imm32
wb_sel  out  2  00 imm32, 01 F reg, 10 MDR, 11 PC+4
illegal  out  1  sticky: illegal encoding trapped
fault  out  1  sticky: memory timeout trapped
state_o  out  4  current state (debug)

Behaviour:
- State register, wait counter and trap flags reset asynchronously.
  - Reset state IDLE; counter 0; illegal = fault = 0.
  - All outputs are decoded combinationally from state, so every enable/request is 0 during and immediately after reset, including a reset asserted mid-access.
- States: IDLE, FETCH, DECODE, RR, EXI, EXB, EXU, MEMR, MEMW, WBI, WBF, WBM, WBP_JPF, WBP_JPR, BR, TRAP.
- IDLE -> FETCH unconditionally.
- FETCH:
  - imem_req=1 and held until imem_ready.
  - In the ready cycle: ir_write=1, pc_step=1, next state DECODE.
- DECODE -> next state by opcode:
  - R, I, LOAD, STORE, BRANCH, JALR -> RR
  - LUI -> WBI
  - AUIPC -> EXU
  - JAL -> WBP_JPR
  - anything else -> TRAP, illegal=1
- Illegal encodings detected in DECODE -> TRAP, illegal=1:
  - Branch funct3 010/011.
  - Load funct3 011/110/111.
  - Store funct3 >= 011.
  - R-type funct7 not 0000000/0100000.
- RR:
  - R, BRANCH -> EXB (alu_rhs_sel=0).
  - Others -> EXI (alu_rhs_sel=1).
- EXU: alu_lhs_sel=1, alu_rhs_sel=1, alu_op=ADD -> WBF.
- EXI:
  - I -> WBF
  - LOAD -> MEMR
  - STORE -> MEMW
  - JALR -> WBP_JPF
- EXB: R -> WBF; BRANCH -> BR.
- MEMR/MEMW:
  - dmem_req=1; dmem_we = (MEMW).
  - dmem_size = funct3[1:0]; dmem_unsigned = funct3[2].
  - Held until dmem_ready. Then MEMR -> WBM, MEMW -> FETCH.
- Write-back states, all 1 cycle then -> FETCH:
  - WBI: regs_write=1, wb_sel=00.
  - WBF: regs_write=1, wb_sel=01.
  - WBM: regs_write=1, wb_sel=10.
  - WBP_JPR: regs_write=1, wb_sel=11, pc_jump=1, pc_jump_sel=0.
  - WBP_JPF: regs_write=1, wb_sel=11, pc_jump=1, pc_jump_sel=1.
- BR: pc_jump = taken, pc_jump_sel=0, then -> FETCH. taken by funct3:
  - 000 zf
  - 001 !zf
  - 100 lt
  - 101 !lt
  - 110 ltu
  - 111 !ltu
- Wait counter:
  - Cleared on entry to FETCH/MEMR/MEMW; increments each non-ready cycle.
  - If TIMEOUT_CYCLES != 0 and count reaches TIMEOUT_CYCLES with ready still low -> TRAP, fault=1.
  - Ready in the same cycle as the limit wins (no fault).
- TRAP: absorbing until rst; all enables/requests 0; illegal/fault held.
- alu_op:
  - From the decoder in RR/EX states.
  - Forced ADD for LOAD/STORE/JALR/AUIPC.
  - Forced SUB for BRANCH.
- Nominal latencies with zero-wait memory:
  - R/I: 5 cycles
  - LOAD: 6
  - STORE: 5
  - LUI: 3
  - AUIPC: 4
  - JAL: 3
  - JALR: 5
  - BRANCH: 5

Decomposition:
- Shared package cpu_pkg:
  - opcode constants
  - state encodings
  - wb_sel, pc_jump_sel, lhs/rhs select, dmem_size constants
  - ALU op codes
- One sub-module: alu_decoder (combinational opcode/funct3/funct7 -> alu_op, plus the illegal flag).

Test Plan:
- ADD x3,x1,x2 with imem_ready/dmem_ready tied 1 -> states FETCH,DECODE,RR,EXB,WBF; regs_write=1 for exactly 1 cycle with wb_sel=01.
- LW with dmem_ready low 3 cycles -> dmem_req=1 for 4 cycles, dmem_size=10, then WBM with wb_sel=10; no fault.
- BNE with zf=0 -> pc_jump=1 in BR; BGEU with ltu=1 -> pc_jump=0; both return to FETCH.
- Opcode 0x7F -> TRAP, illegal=1, all enables 0 for 20 cycles; rst clears to IDLE.
- TIMEOUT_CYCLES=4, imem_ready held low -> TRAP with fault=1 after 4 wait cycles; ready on cycle 4 instead -> DECODE, no fault.
- rst asserted mid-MEMW -> dmem_req drops in the same cycle; state_o=IDLE.

Source files
------------

// File: rtl/cu_mc_hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cu_mc_hs_pkg
//  Purpose  : Shared constants for the RV32I multicycle control unit: opcode
//             values, FSM state encodings, datapath select codes and ALU
//             operation codes, plus the branch-condition helper.
//  Revision : 1.0  initial release
// ============================================================================
package cu_mc_hs_pkg;

    // RV32I major opcodes handled by this control unit
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // FSM state encodings (all 16 codes are used, so state_o is dense)
    localparam logic [3:0] c_st_idle    = 4'd0;
    localparam logic [3:0] c_st_fetch   = 4'd1;
    localparam logic [3:0] c_st_decode  = 4'd2;
    localparam logic [3:0] c_st_rr      = 4'd3;
    localparam logic [3:0] c_st_exi     = 4'd4;
    localparam logic [3:0] c_st_exb     = 4'd5;
    localparam logic [3:0] c_st_exu     = 4'd6;
    localparam logic [3:0] c_st_memr    = 4'd7;
    localparam logic [3:0] c_st_memw    = 4'd8;
    localparam logic [3:0] c_st_wbi     = 4'd9;
    localparam logic [3:0] c_st_wbf     = 4'd10;
    localparam logic [3:0] c_st_wbm     = 4'd11;
    localparam logic [3:0] c_st_wbp_jpf = 4'd12;
    localparam logic [3:0] c_st_wbp_jpr = 4'd13;
    localparam logic [3:0] c_st_br      = 4'd14;
    localparam logic [3:0] c_st_trap    = 4'd15;

    // Write-back source select
    localparam logic [1:0] c_wb_imm = 2'b00;
    localparam logic [1:0] c_wb_f   = 2'b01;
    localparam logic [1:0] c_wb_mdr = 2'b10;
    localparam logic [1:0] c_wb_pc4 = 2'b11;

    // PC jump source and ALU operand selects
    localparam logic c_jsel_rel = 1'b0;
    localparam logic c_jsel_f   = 1'b1;
    localparam logic c_lhs_a    = 1'b0;
    localparam logic c_lhs_pc   = 1'b1;
    localparam logic c_rhs_b    = 1'b0;
    localparam logic c_rhs_imm  = 1'b1;

    // Data memory access sizes (equal to funct3[1:0] of loads/stores)
    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    // ALU operation codes
    localparam logic [3:0] c_alu_add  = 4'd0;
    localparam logic [3:0] c_alu_sub  = 4'd1;
    localparam logic [3:0] c_alu_sll  = 4'd2;
    localparam logic [3:0] c_alu_slt  = 4'd3;
    localparam logic [3:0] c_alu_sltu = 4'd4;
    localparam logic [3:0] c_alu_xor  = 4'd5;
    localparam logic [3:0] c_alu_srl  = 4'd6;
    localparam logic [3:0] c_alu_sra  = 4'd7;
    localparam logic [3:0] c_alu_or   = 4'd8;
    localparam logic [3:0] c_alu_and  = 4'd9;

    // Instruction class produced by the decoder
    typedef enum logic [3:0] {
        c_cls_r,
        c_cls_i,
        c_cls_load,
        c_cls_store,
        c_cls_branch,
        c_cls_jalr,
        c_cls_lui,
        c_cls_auipc,
        c_cls_jal,
        c_cls_bad
    } op_class_t;

    // Branch condition from the ALU flags; unused funct3 codes never take
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zf,
                                          input logic lt,
                                          input logic ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zf;
            3'b001:  taken = ~zf;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cu_mc_hs_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : cu_mc_hs_alu_decoder
//  Purpose  : Combinational instruction decode: instruction class, ALU
//             operation and illegal-encoding flag from opcode/funct3/funct7.
//  Revision : 1.0  initial release
// ============================================================================
module cu_mc_hs_alu_decoder
    import cu_mc_hs_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output op_class_t  op_class,
    output logic [3:0] alu_op,
    output logic       illegal
);

    logic [3:0] w_arith_op;

    // Classify the major opcode
    always_comb begin
        op_class = c_cls_bad;
        case (opcode)
            c_op_r:      op_class = c_cls_r;
            c_op_i:      op_class = c_cls_i;
            c_op_load:   op_class = c_cls_load;
            c_op_store:  op_class = c_cls_store;
            c_op_branch: op_class = c_cls_branch;
            c_op_jalr:   op_class = c_cls_jalr;
            c_op_lui:    op_class = c_cls_lui;
            c_op_auipc:  op_class = c_cls_auipc;
            c_op_jal:    op_class = c_cls_jal;
            default:     op_class = c_cls_bad;
        endcase
    end

    // Arithmetic op for R/I; funct7[5] picks SUB (R only) and SRA
    always_comb begin
        w_arith_op = c_alu_add;
        case (funct3)
            3'b000:  w_arith_op = (op_class == c_cls_r && funct7[5]) ? c_alu_sub : c_alu_add;
            3'b001:  w_arith_op = c_alu_sll;
            3'b010:  w_arith_op = c_alu_slt;
            3'b011:  w_arith_op = c_alu_sltu;
            3'b100:  w_arith_op = c_alu_xor;
            3'b101:  w_arith_op = funct7[5] ? c_alu_sra : c_alu_srl;
            3'b110:  w_arith_op = c_alu_or;
            default: w_arith_op = c_alu_and;
        endcase
    end

    // Address/PC computations add, branches compare by subtraction
    always_comb begin
        alu_op = c_alu_add;
        case (op_class)
            c_cls_r, c_cls_i: alu_op = w_arith_op;
            c_cls_branch:     alu_op = c_alu_sub;
            default:          alu_op = c_alu_add;
        endcase
    end

    // Encodings this core cannot execute
    always_comb begin
        illegal = 1'b0;
        case (op_class)
            c_cls_bad:    illegal = 1'b1;
            c_cls_branch: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            c_cls_load:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            c_cls_store:  illegal = (funct3 >= 3'b011);
            c_cls_r:      illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            default:      illegal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cu_mc_hs.sv
`default_nettype none
// ============================================================================
//  Module   : cu_mc_hs
//  Purpose  : RV32I multicycle control unit (Moore FSM) with ready-based
//             instruction/data memory handshakes, wait timeout and sticky
//             illegal/fault trap state.
//  Revision : 1.0  initial release
// ============================================================================
module cu_mc_hs
    import cu_mc_hs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zf,
    input  logic       lt,
    input  logic       ltu,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       pc_step,
    output logic       pc_jump,
    output logic       pc_jump_sel,
    output logic       ir_write,
    output logic       regs_write,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [1:0] dmem_size,
    output logic       dmem_unsigned,
    output logic [3:0] alu_op,
    output logic       alu_lhs_sel,
    output logic       alu_rhs_sel,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       fault,
    output logic [3:0] state_o
);

    // A zero timeout disables the counter; keep at least one bit so the
    // declarations stay legal in that case.
    localparam int               TO_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic             c_to_en     = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0]  c_wait_last = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [3:0]      r_state;
    logic [3:0]      w_state_nxt;
    logic [TO_W-1:0] r_wait;
    logic            r_illegal;
    logic            r_fault;

    op_class_t       w_cls;
    logic [3:0]      w_dec_alu_op;
    logic            w_dec_illegal;
    logic            w_waiting;
    logic            w_ready;
    logic            w_expired;
    logic            w_rb_class;

    cu_mc_hs_alu_decoder u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .op_class (w_cls),
        .alu_op   (w_dec_alu_op),
        .illegal  (w_dec_illegal)
    );

    // Handshake wait bookkeeping: the limit is hit on the cycle whose wait
    // would make the count reach TIMEOUT_CYCLES; ready in that cycle wins.
    assign w_waiting  = (r_state == c_st_fetch) || (r_state == c_st_memr) || (r_state == c_st_memw);
    assign w_ready    = (r_state == c_st_fetch) ? imem_ready : dmem_ready;
    assign w_expired  = c_to_en && w_waiting && !w_ready && (r_wait == c_wait_last);
    assign w_rb_class = (w_cls == c_cls_r) || (w_cls == c_cls_branch);

    // Next-state sequencing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   w_state_nxt = c_st_fetch;
            c_st_fetch: begin
                if (imem_ready)     w_state_nxt = c_st_decode;
                else if (w_expired) w_state_nxt = c_st_trap;
            end
            c_st_decode: begin
                if (w_dec_illegal) begin
                    w_state_nxt = c_st_trap;
                end else begin
                    case (w_cls)
                        c_cls_lui:   w_state_nxt = c_st_wbi;
                        c_cls_auipc: w_state_nxt = c_st_exu;
                        c_cls_jal:   w_state_nxt = c_st_wbp_jpr;
                        c_cls_bad:   w_state_nxt = c_st_trap;
                        default:     w_state_nxt = c_st_rr;
                    endcase
                end
            end
            c_st_rr:     w_state_nxt = w_rb_class ? c_st_exb : c_st_exi;
            c_st_exu:    w_state_nxt = c_st_wbf;
            c_st_exi: begin
                case (w_cls)
                    c_cls_load:  w_state_nxt = c_st_memr;
                    c_cls_store: w_state_nxt = c_st_memw;
                    c_cls_jalr:  w_state_nxt = c_st_wbp_jpf;
                    default:     w_state_nxt = c_st_wbf;
                endcase
            end
            c_st_exb:    w_state_nxt = (w_cls == c_cls_branch) ? c_st_br : c_st_wbf;
            c_st_memr: begin
                if (dmem_ready)     w_state_nxt = c_st_wbm;
                else if (w_expired) w_state_nxt = c_st_trap;
            end
            c_st_memw: begin
                if (dmem_ready)     w_state_nxt = c_st_fetch;
                else if (w_expired) w_state_nxt = c_st_trap;
            end
            c_st_wbi, c_st_wbf, c_st_wbm,
            c_st_wbp_jpf, c_st_wbp_jpr, c_st_br:
                         w_state_nxt = c_st_fetch;
            c_st_trap:   w_state_nxt = c_st_trap;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Wait counter: counts non-ready cycles, zero whenever not stalled so
    // every FETCH/MEMR/MEMW visit starts from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_wait <= '0;
        else if (c_to_en && w_waiting && !w_ready) r_wait <= r_wait + TO_W'(1);
        else                                      r_wait <= '0;
    end

    // Sticky trap causes, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            if (r_state == c_st_decode && w_dec_illegal) r_illegal <= 1'b1;
            if (w_expired)                               r_fault   <= 1'b1;
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        imem_req      = 1'b0;
        pc_step       = 1'b0;
        pc_jump       = 1'b0;
        pc_jump_sel   = c_jsel_rel;
        ir_write      = 1'b0;
        regs_write    = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_size     = c_size_byte;
        dmem_unsigned = 1'b0;
        alu_op        = c_alu_add;
        alu_lhs_sel   = c_lhs_a;
        alu_rhs_sel   = c_rhs_b;
        wb_sel        = c_wb_imm;
        case (r_state)
            c_st_fetch: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_step  = imem_ready;
            end
            c_st_rr: begin
                alu_op      = w_dec_alu_op;
                alu_rhs_sel = w_rb_class ? c_rhs_b : c_rhs_imm;
            end
            c_st_exi: begin
                alu_op      = w_dec_alu_op;
                alu_rhs_sel = c_rhs_imm;
            end
            c_st_exb: begin
                alu_op      = w_dec_alu_op;
                alu_rhs_sel = c_rhs_b;
            end
            c_st_exu: begin
                alu_op      = c_alu_add;
                alu_lhs_sel = c_lhs_pc;
                alu_rhs_sel = c_rhs_imm;
            end
            c_st_memr, c_st_memw: begin
                dmem_req      = 1'b1;
                dmem_we       = (r_state == c_st_memw);
                dmem_size     = funct3[1:0];
                dmem_unsigned = funct3[2];
            end
            c_st_wbi: begin
                regs_write = 1'b1;
                wb_sel     = c_wb_imm;
            end
            c_st_wbf: begin
                regs_write = 1'b1;
                wb_sel     = c_wb_f;
            end
            c_st_wbm: begin
                regs_write = 1'b1;
                wb_sel     = c_wb_mdr;
            end
            c_st_wbp_jpr: begin
                regs_write  = 1'b1;
                wb_sel      = c_wb_pc4;
                pc_jump     = 1'b1;
                pc_jump_sel = c_jsel_rel;
            end
            c_st_wbp_jpf: begin
                regs_write  = 1'b1;
                wb_sel      = c_wb_pc4;
                pc_jump     = 1'b1;
                pc_jump_sel = c_jsel_f;
            end
            c_st_br: begin
                pc_jump     = branch_taken(funct3, zf, lt, ltu);
                pc_jump_sel = c_jsel_rel;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;
    assign fault   = r_fault;
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cu_mc_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cu_mc_hs
//  Purpose  : Self-checking bench for cu_mc_hs. Each instruction is expanded
//             from the ISA rules into an expected per-cycle output trace,
//             including memory wait/timeout behaviour, and compared cycle by
//             cycle against the control unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cu_mc_hs;
    import cu_mc_hs_pkg::*;

    localparam int TIMEOUT    = 4;
    localparam int NUM_RANDOM = 150;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_JALR = 5, K_LUI = 6, K_AUIPC = 7, K_JAL = 8, K_BAD = 9;

    typedef struct packed {
        logic       imem_req;
        logic       pc_step;
        logic       pc_jump;
        logic       pc_jump_sel;
        logic       ir_write;
        logic       regs_write;
        logic       dmem_req;
        logic       dmem_we;
        logic [1:0] dmem_size;
        logic       dmem_unsigned;
        logic [3:0] alu_op;
        logic       alu_lhs_sel;
        logic       alu_rhs_sel;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       fault;
    } outs_t;

    typedef struct packed {
        logic  imem_ready;
        logic  dmem_ready;
        outs_t exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'h00;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zf = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic       imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, pc_step, pc_jump, pc_jump_sel, ir_write, regs_write;
    logic       dmem_req, dmem_we, dmem_unsigned, alu_lhs_sel, alu_rhs_sel;
    logic       illegal, fault;
    logic [1:0] dmem_size, wb_sel;
    logic [3:0] alu_op, state_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ninstr = 0;
    cyc_t q[$];
    bit   plan_trap;

    cu_mc_hs #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zf(zf), .lt(lt), .ltu(ltu), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .pc_step(pc_step), .pc_jump(pc_jump), .pc_jump_sel(pc_jump_sel),
        .ir_write(ir_write), .regs_write(regs_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_size(dmem_size), .dmem_unsigned(dmem_unsigned), .alu_op(alu_op),
        .alu_lhs_sel(alu_lhs_sel), .alu_rhs_sel(alu_rhs_sel), .wb_sel(wb_sel),
        .illegal(illegal), .fault(fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic outs_t get_obs();
        outs_t o;
        o.imem_req = imem_req;     o.pc_step = pc_step;       o.pc_jump = pc_jump;
        o.pc_jump_sel = pc_jump_sel; o.ir_write = ir_write;   o.regs_write = regs_write;
        o.dmem_req = dmem_req;     o.dmem_we = dmem_we;       o.dmem_size = dmem_size;
        o.dmem_unsigned = dmem_unsigned; o.alu_op = alu_op;   o.alu_lhs_sel = alu_lhs_sel;
        o.alu_rhs_sel = alu_rhs_sel; o.wb_sel = wb_sel;       o.illegal = illegal;
        o.fault = fault;
        return o;
    endfunction

    function automatic outs_t base();
        outs_t o;
        o = '0;
        o.alu_op = c_alu_add;
        return o;
    endfunction

    function automatic logic rbit();
        return logic'($urandom % 2);
    endfunction

    function automatic logic [6:0] opc_of(input int k);
        case (k)
            K_R:     return 7'h33;
            K_I:     return 7'h13;
            K_LD:    return 7'h03;
            K_ST:    return 7'h23;
            K_BR:    return 7'h63;
            K_JALR:  return 7'h67;
            K_LUI:   return 7'h37;
            K_AUIPC: return 7'h17;
            K_JAL:   return 7'h6F;
            default: begin
                case ($urandom % 4)
                    0:       return 7'h7F;
                    1:       return 7'h0F;
                    2:       return 7'h73;
                    default: return 7'h00;
                endcase
            end
        endcase
    endfunction

    function automatic bit is_illegal(input int k, input logic [2:0] f3, input logic [6:0] f7);
        case (k)
            K_BAD:   return 1'b1;
            K_BR:    return (f3 == 3'd2 || f3 == 3'd3);
            K_LD:    return (f3 == 3'd3 || f3 >= 3'd6);
            K_ST:    return (f3 >= 3'd3);
            K_R:     return !(f7 == 7'h00 || f7 == 7'h20);
            default: return 1'b0;
        endcase
    endfunction

    // RV32I meaning of funct3/funct7 for register/immediate arithmetic
    function automatic logic [3:0] ref_alu(input int k, input logic [2:0] f3, input logic [6:0] f7);
        if (k == K_BR) return c_alu_sub;
        if (k != K_R && k != K_I) return c_alu_add;
        case (f3)
            3'd0:    return (k == K_R && f7 == 7'h20) ? c_alu_sub : c_alu_add;
            3'd1:    return c_alu_sll;
            3'd2:    return c_alu_slt;
            3'd3:    return c_alu_sltu;
            3'd4:    return c_alu_xor;
            3'd5:    return (f7 == 7'h20) ? c_alu_sra : c_alu_srl;
            3'd6:    return c_alu_or;
            default: return c_alu_and;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic ir, input logic dr, input outs_t o);
        cyc_t c;
        c.imem_ready = ir;
        c.dmem_ready = dr;
        c.exp = o;
        q.push_back(c);
    endtask

    task automatic push_trap(input int n, input bit is_fault);
        outs_t o;
        o = base();
        o.fault = is_fault;
        o.illegal = !is_fault;
        for (int i = 0; i < n; i++) push(rbit(), rbit(), o);
        plan_trap = 1'b1;
    endtask

    // Expand one instruction into its expected cycle trace
    task automatic plan(input int k, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input logic l, input logic lu,
                        input int iw, input int dw, input int ntrap);
        outs_t o;
        q.delete();
        plan_trap = 1'b0;
        for (int i = 0; i < iw && i < TIMEOUT; i++) begin
            o = base(); o.imem_req = 1'b1;
            push(1'b0, rbit(), o);
        end
        if (iw >= TIMEOUT) begin push_trap(ntrap, 1'b1); return; end
        o = base(); o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_step = 1'b1;
        push(1'b1, rbit(), o);
        push(rbit(), rbit(), base());
        if (is_illegal(k, f3, f7)) begin push_trap(ntrap, 1'b0); return; end
        case (k)
            K_LUI: begin
                o = base(); o.regs_write = 1'b1; o.wb_sel = 2'b00;
                push(rbit(), rbit(), o);
            end
            K_JAL: begin
                o = base(); o.regs_write = 1'b1; o.wb_sel = 2'b11; o.pc_jump = 1'b1;
                push(rbit(), rbit(), o);
            end
            K_AUIPC: begin
                o = base(); o.alu_lhs_sel = 1'b1; o.alu_rhs_sel = 1'b1;
                push(rbit(), rbit(), o);
                o = base(); o.regs_write = 1'b1; o.wb_sel = 2'b01;
                push(rbit(), rbit(), o);
            end
            default: begin
                o = base();
                o.alu_op = ref_alu(k, f3, f7);
                o.alu_rhs_sel = (k == K_R || k == K_BR) ? 1'b0 : 1'b1;
                push(rbit(), rbit(), o);
                push(rbit(), rbit(), o);
                if (k == K_LD || k == K_ST) begin
                    o = base(); o.dmem_req = 1'b1; o.dmem_we = (k == K_ST);
                    o.dmem_size = f3[1:0]; o.dmem_unsigned = f3[2];
                    for (int i = 0; i < dw && i < TIMEOUT; i++) push(rbit(), 1'b0, o);
                    if (dw >= TIMEOUT) begin push_trap(ntrap, 1'b1); return; end
                    push(rbit(), 1'b1, o);
                    if (k == K_LD) begin
                        o = base(); o.regs_write = 1'b1; o.wb_sel = 2'b10;
                        push(rbit(), rbit(), o);
                    end
                end else if (k == K_JALR) begin
                    o = base(); o.regs_write = 1'b1; o.wb_sel = 2'b11;
                    o.pc_jump = 1'b1; o.pc_jump_sel = 1'b1;
                    push(rbit(), rbit(), o);
                end else if (k == K_BR) begin
                    o = base(); o.pc_jump = ref_taken(f3, z, l, lu);
                    push(rbit(), rbit(), o);
                end else begin
                    o = base(); o.regs_write = 1'b1; o.wb_sel = 2'b01;
                    push(rbit(), rbit(), o);
                end
            end
        endcase
    endtask

    // Play up to limit planned cycles (all when limit < 0)
    task automatic exec(input int limit);
        int   n;
        cyc_t c;
        n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            imem_ready = c.imem_ready;
            dmem_ready = c.dmem_ready;
            @(negedge clk);
            check($sformatf("instr%0d_cyc%0d", ninstr, n), 64'(get_obs()), 64'(c.exp));
            n++;
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_outs", 64'(get_obs()), 64'(base()));
        check("rst_state", 64'(state_o), 64'(c_st_idle));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_outs", 64'(get_obs()), 64'(base()));
        check("idle_state", 64'(state_o), 64'(c_st_idle));
    endtask

    task automatic run_instr(input int k, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic l, input logic lu,
                             input int iw, input int dw, input int ntrap);
        opcode = opc; funct3 = f3; funct7 = f7;
        zf = z; lt = l; ltu = lu;
        plan(k, f3, f7, z, l, lu, iw, dw, ntrap);
        exec(-1);
        if (plan_trap) begin
            check($sformatf("instr%0d_trap_state", ninstr), 64'(state_o), 64'(c_st_trap));
            do_reset();
        end
        ninstr++;
    endtask

    initial begin
        int         k;
        logic [2:0] f3;
        logic [6:0] f7;
        int         iw, dw;

        do_reset();

        // Directed: ADD, LW with 3 data waits, BNE taken, BGEU not taken
        run_instr(K_R,  7'h33, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 3);
        run_instr(K_LD, 7'h03, 3'b010, 7'h00, 1'b0, 1'b0, 1'b0, 0, 3, 3);
        run_instr(K_BR, 7'h63, 3'b001, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 3);
        run_instr(K_BR, 7'h63, 3'b111, 7'h00, 1'b0, 1'b0, 1'b1, 0, 0, 3);
        // Ready on the last allowed wait cycle, then the timeout itself
        run_instr(K_LUI, 7'h37, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, TIMEOUT - 1, 0, 3);
        run_instr(K_R,   7'h33, 3'b000, 7'h20, 1'b0, 1'b0, 1'b0, TIMEOUT, 0, 3);
        run_instr(K_ST,  7'h23, 3'b001, 7'h00, 1'b0, 1'b0, 1'b0, 0, TIMEOUT, 3);
        // Illegal opcode held in trap for 20 cycles
        run_instr(K_BAD, 7'h7F, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, 20);

        // Reset asserted during a stalled store
        opcode = 7'h23; funct3 = 3'b010; funct7 = 7'h00;
        plan(K_ST, 3'b010, 7'h00, 1'b0, 1'b0, 1'b0, 0, 3, 3);
        exec(5);
        check("memw_req_before_rst", 64'(dmem_req), 64'(1));
        q.delete();
        do_reset();
        ninstr++;

        for (int n = 0; n < NUM_RANDOM; n++) begin
            k  = int'($urandom % 10);
            f3 = 3'($urandom);
            if (k == K_R && ($urandom % 8) == 0) f7 = 7'($urandom);
            else                                 f7 = ($urandom % 2) ? 7'h20 : 7'h00;
            iw = (($urandom % 5) == 0) ? int'($urandom_range(1, 5)) : 0;
            dw = (($urandom % 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_instr(k, opc_of(k), f3, f7, rbit(), rbit(), rbit(), iw, dw, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
